mdu_unit: RTL and testbench

- Multiply/divide unit that owns the HI/LO registers; sits directly downstream of the execution FU and consumes its mdu_start/mdu_op/operand request.
- Single-cycle HI/LO moves; fixed-latency multiplier; iterative radix-2 divider.
- Uses a same-cycle mdu_recv handshake: the FU stalls while mdu_recv is low.

---
 rtl/mdu_unit_pkg.sv | 36 +++
 rtl/mdu_unit_div_radix2.sv | 78 +++++++
 rtl/mdu_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_mdu_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the multiply/divide unit: the operation code the FU
// decodes, the controller states and a signedness helper.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MULT  = 4'h1,
    OP_MULTU = 4'h2,
    OP_DIV   = 4'h3,
    OP_DIVU  = 4'h4,
    OP_MFHI  = 4'h5,
    OP_MFLO  = 4'h6,
    OP_MTHI  = 4'h7,
    OP_MTLO  = 4'h8,
    OP_MUL   = 4'h9,
    OP_MADD  = 4'hA,
    OP_MADDU = 4'hB,
    OP_MSUB  = 4'hC,
    OP_MSUBU = 4'hD
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_GMUL_RUN = 2'd2,
    ST_DIV_RUN  = 2'd3
  } mdu_state_e;

  localparam int DIV_STEPS = 32;

  // MUL to GPR follows the signed MULT semantics.
  function automatic logic isSignedMul(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/mdu_unit_div_radix2.sv
// Iterative restoring divider: 32 shift/subtract steps on operand magnitudes,
// followed by one done cycle that presents the sign-corrected results.
module div_radix2
  import mdu_unit_pkg::*;
#(
  parameter int EARLY_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic        r_busy;
  logic [5:0]  r_cnt;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [31:0] r_rawA;
  logic        r_negQ;
  logic        r_negR;
  logic        r_zero;

  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_partial;
  logic        w_ge;
  logic [31:0] w_diff;

  assign w_absA    = (i_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_absB    = (i_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
  assign w_partial = {r_rem, r_quot[31]};
  assign w_ge      = (w_partial >= {1'b0, r_div});
  // The remainder stays below the divisor, so the difference always fits 32 bits.
  assign w_diff    = w_partial[31:0] - r_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= 6'd0;
      r_quot <= 32'd0;
      r_rem  <= 32'd0;
      r_div  <= 32'd0;
      r_rawA <= 32'd0;
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
      r_zero <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= ((i_b == 32'd0) && (EARLY_ZERO != 0)) ? 6'd0 : 6'(DIV_STEPS);
      r_quot <= w_absA;
      r_rem  <= 32'd0;
      r_div  <= w_absB;
      r_rawA <= i_a;
      r_negQ <= i_signed & (i_a[31] ^ i_b[31]);
      r_negR <= i_signed & i_a[31];
      r_zero <= (i_b == 32'd0);
    end else if (r_busy) begin
      if (r_cnt != 6'd0) begin
        r_rem  <= w_ge ? w_diff : w_partial[31:0];
        r_quot <= {r_quot[30:0], w_ge};
        r_cnt  <= r_cnt - 6'd1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == 6'd0);
  assign o_quot = r_zero ? 32'hFFFF_FFFF : (r_negQ ? (32'd0 - r_quot) : r_quot);
  assign o_rem  = r_zero ? r_rawA : (r_negR ? (32'd0 - r_rem) : r_rem);

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO: single-cycle moves, fixed-latency
// multiplier pipeline, and an iterative divider, all behind the mdu_recv handshake.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MUL_CYCLES     = 2,
  parameter int DIV_EARLY_ZERO = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] mdu_srcA,
  input  logic [31:0] mdu_srcB,
  input  logic        mdu_start,
  input  logic        mdu_started,
  output logic        mdu_recv,
  output logic [31:0] mdu_result,
  output logic        mdu_busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] MulCntInit = 8'(MUL_CYCLES - 1);

  mdu_op_e     w_op;
  mdu_state_e  r_state;
  mdu_state_e  w_nextState;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  mdu_op_e     r_op;
  logic [7:0]  r_count;
  logic [63:0] r_pipe [MUL_CYCLES];
  logic        r_gmulReady;
  logic [31:0] r_gmulRes;

  logic        w_hiWe;
  logic        w_loWe;
  logic [31:0] w_hiNext;
  logic [31:0] w_loNext;
  logic        w_mulAccept;
  logic        w_divStart;
  logic        w_countDec;
  logic        w_gmulCapture;
  logic        w_gmulClear;

  logic        w_mulSigned;
  logic [63:0] w_extA;
  logic [63:0] w_extB;
  logic [63:0] w_product;
  logic [63:0] w_pipeOut;
  logic [63:0] w_hilo;
  logic [63:0] w_mulResult;
  logic [31:0] w_gmulVal;

  logic        w_divDone;
  logic [31:0] w_divQuot;
  logic [31:0] w_divRem;

  assign w_op = mdu_op_e'(mdu_op);

  // Extending both operands to 64 bits gives the exact 33x33 signed product
  // for either signedness; the low 64 bits are all HI/LO ever needs.
  assign w_mulSigned = isSignedMul(w_op);
  assign w_extA      = w_mulSigned ? {{32{mdu_srcA[31]}}, mdu_srcA} : {32'd0, mdu_srcA};
  assign w_extB      = w_mulSigned ? {{32{mdu_srcB[31]}}, mdu_srcB} : {32'd0, mdu_srcB};
  assign w_product   = w_extA * w_extB;
  assign w_pipeOut   = r_pipe[MUL_CYCLES-1];
  assign w_hilo      = {r_hi, r_lo};
  assign w_gmulVal   = r_gmulReady ? r_gmulRes : w_pipeOut[31:0];

  always_comb begin
    case (r_op)
      OP_MADD, OP_MADDU: w_mulResult = w_hilo + w_pipeOut;
      OP_MSUB, OP_MSUBU: w_mulResult = w_hilo - w_pipeOut;
      default:           w_mulResult = w_pipeOut;
    endcase
  end

  div_radix2 #(
    .EARLY_ZERO(DIV_EARLY_ZERO)
  ) u_div (
    .clk     (clk),
    .rst_n   (resetn),
    .i_start (w_divStart),
    .i_signed(w_op == OP_DIV),
    .i_a     (mdu_srcA),
    .i_b     (mdu_srcB),
    .o_done  (w_divDone),
    .o_quot  (w_divQuot),
    .o_rem   (w_divRem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    mdu_recv      = 1'b0;
    mdu_result    = 32'd0;
    w_hiWe        = 1'b0;
    w_loWe        = 1'b0;
    w_hiNext      = r_hi;
    w_loNext      = r_lo;
    w_mulAccept   = 1'b0;
    w_divStart    = 1'b0;
    w_countDec    = 1'b0;
    w_gmulCapture = 1'b0;
    w_gmulClear   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mdu_start) begin
          case (w_op)
            OP_MTHI: begin
              mdu_recv = 1'b1;
              w_hiWe   = 1'b1;
              w_hiNext = mdu_srcA;
            end
            OP_MTLO: begin
              mdu_recv = 1'b1;
              w_loWe   = 1'b1;
              w_loNext = mdu_srcA;
            end
            OP_MFHI: begin
              mdu_recv   = 1'b1;
              mdu_result = r_hi;
            end
            OP_MFLO: begin
              mdu_recv   = 1'b1;
              mdu_result = r_lo;
            end
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              mdu_recv    = 1'b1;
              w_mulAccept = 1'b1;
              w_nextState = ST_MUL_RUN;
            end
            OP_MUL: begin
              // A requester already marked started is waiting on a hand-off, never a restart.
              if (!mdu_started) begin
                mdu_recv    = 1'b1;
                w_mulAccept = 1'b1;
                w_nextState = ST_GMUL_RUN;
              end
            end
            OP_DIV, OP_DIVU: begin
              mdu_recv    = 1'b1;
              w_divStart  = 1'b1;
              w_nextState = ST_DIV_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (r_count == 8'd0) begin
          w_hiWe                 = 1'b1;
          w_loWe                 = 1'b1;
          {w_hiNext, w_loNext}   = w_mulResult;
          w_nextState            = ST_IDLE;
        end else begin
          w_countDec = 1'b1;
        end
      end
      ST_GMUL_RUN: begin
        if (!mdu_start && !mdu_started) begin
          w_gmulClear = 1'b1;
          w_nextState = ST_IDLE;
        end else if (r_count != 8'd0) begin
          w_countDec = 1'b1;
        end else if (mdu_start && mdu_started && (w_op == OP_MUL)) begin
          mdu_recv    = 1'b1;
          mdu_result  = w_gmulVal;
          w_gmulClear = 1'b1;
          w_nextState = ST_IDLE;
        end else begin
          w_gmulCapture = !r_gmulReady;
        end
      end
      ST_DIV_RUN: begin
        if (w_divDone) begin
          w_hiWe      = 1'b1;
          w_loWe      = 1'b1;
          w_hiNext    = w_divRem;
          w_loNext    = w_divQuot;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_op        <= OP_NOP;
      r_count     <= 8'd0;
      r_gmulReady <= 1'b0;
      r_gmulRes   <= 32'd0;
    end else begin
      if (w_hiWe) r_hi <= w_hiNext;
      if (w_loWe) r_lo <= w_loNext;
      if (w_mulAccept) begin
        r_op    <= w_op;
        r_count <= MulCntInit;
      end else if (w_countDec) begin
        r_count <= r_count - 8'd1;
      end
      if (w_gmulCapture) begin
        r_gmulReady <= 1'b1;
        r_gmulRes   <= w_pipeOut[31:0];
      end else if (w_gmulClear) begin
        r_gmulReady <= 1'b0;
      end
    end
  end

  // Free-running product pipeline; its last stage lines up with count reaching zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_CYCLES; i++) r_pipe[i] <= 64'd0;
    end else begin
      r_pipe[0] <= w_product;
      for (int i = 1; i < MUL_CYCLES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign mdu_busy = (r_state != ST_IDLE);
  assign hi_o     = r_hi;
  assign lo_o     = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a table of HI/LO-writing ops with expected
// latency and results, plus hand sequences for stalls, GPR MUL and flush.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int MulCycles = 2;
  localparam int DivBusy   = 33;
  localparam int NumVecs   = 17;

  logic        clk;
  logic        resetn;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_srcA;
  logic [31:0] mdu_srcB;
  logic        mdu_start;
  logic        mdu_started;
  logic        mdu_recv;
  logic [31:0] mdu_result;
  logic        mdu_busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total;
  int bad;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          expBusy;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs [NumVecs];

  mdu_unit #(
    .MUL_CYCLES    (MulCycles),
    .DIV_EARLY_ZERO(1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mdu_op     (mdu_op),
    .mdu_srcA   (mdu_srcA),
    .mdu_srcB   (mdu_srcB),
    .mdu_start  (mdu_start),
    .mdu_started(mdu_started),
    .mdu_recv   (mdu_recv),
    .mdu_result (mdu_result),
    .mdu_busy   (mdu_busy),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of FU request at the falling edge and let outputs settle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic st, input logic sd);
    @(negedge clk);
    mdu_op      = op;
    mdu_srcA    = a;
    mdu_srcB    = b;
    mdu_start   = st;
    mdu_started = sd;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int busyCnt;
    total = 0;
    bad   = 0;

    vecs[0]  = '{OP_MTHI,  32'h0000_1234, 32'h0,          0,         32'h0000_1234, 32'h0000_0000};
    vecs[1]  = '{OP_MTLO,  32'h0000_000A, 32'h0,          0,         32'h0000_1234, 32'h0000_000A};
    vecs[2]  = '{OP_MTHI,  32'h0,         32'h0,          0,         32'h0000_0000, 32'h0000_000A};
    vecs[3]  = '{OP_MADD,  32'd3,         32'd4,          MulCycles, 32'h0000_0000, 32'h0000_0016};
    vecs[4]  = '{OP_MSUBU, 32'd1,         32'd23,         MulCycles, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,          MulCycles, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[6]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,          MulCycles, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[7]  = '{OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  MulCycles, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_MSUB,  32'd2,         32'd3,          MulCycles, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,          DivBusy,   32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[10] = '{OP_DIVU,  32'd100,       32'd7,          DivBusy,   32'h0000_0002, 32'h0000_000E};
    vecs[11] = '{OP_DIV,   32'h1234_5678, 32'd0,          1,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[12] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  DivBusy,   32'h0000_0000, 32'h8000_0000};
    vecs[13] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE,  DivBusy,   32'h0000_0001, 32'hFFFF_FFFD};
    vecs[14] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,         DivBusy,   32'h0000_0005, 32'h1999_9999};
    vecs[15] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000,  MulCycles, 32'h4000_0000, 32'h0000_0000};
    vecs[16] = '{OP_MTLO,  32'h0000_0055, 32'h0,          0,         32'h4000_0000, 32'h0000_0055};

    resetn      = 1'b0;
    mdu_op      = OP_NOP;
    mdu_srcA    = 32'd0;
    mdu_srcB    = 32'd0;
    mdu_start   = 1'b0;
    mdu_started = 1'b0;
    #1;
    checkOutput("reset recv",   32'(mdu_recv), 32'd0);
    checkOutput("reset result", mdu_result,    32'd0);
    checkOutput("reset busy",   32'(mdu_busy), 32'd0);
    checkOutput("reset hi",     hi_o,          32'd0);
    checkOutput("reset lo",     lo_o,          32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Back-to-back MTHI then MFHI, then an asynchronous reset in the middle of a divide.
    applyStimulus(OP_MTHI, 32'h0000_BEEF, 32'd0, 1'b1, 1'b0);
    checkOutput("mthi accept", 32'(mdu_recv), 32'd1);
    applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("mfhi recv",   32'(mdu_recv), 32'd1);
    checkOutput("mfhi result", mdu_result,    32'h0000_BEEF);
    applyStimulus(OP_DIV, 32'd100, 32'd3, 1'b1, 1'b0);
    checkOutput("div accept", 32'(mdu_recv), 32'd1);
    idleCycle();
    idleCycle();
    checkOutput("div busy", 32'(mdu_busy), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("midreset hi",   hi_o,          32'd0);
    checkOutput("midreset busy", 32'(mdu_busy), 32'd0);
    idleCycle();
    resetn = 1'b1;

    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      checkOutput($sformatf("v%0d accept", i), 32'(mdu_recv), 32'd1);
      busyCnt = 0;
      for (int c = 0; c < 100; c++) begin
        idleCycle();
        if (!mdu_busy) break;
        busyCnt++;
      end
      checkOutput($sformatf("v%0d busy cycles", i), 32'(busyCnt), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d hi", i), hi_o, vecs[i].expHi);
      checkOutput($sformatf("v%0d lo", i), lo_o, vecs[i].expLo);
      applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput($sformatf("v%0d mflo recv", i),   32'(mdu_recv), 32'd1);
      checkOutput($sformatf("v%0d mflo result", i), mdu_result,    vecs[i].expLo);
    end

    // MFLO issued right behind a MULT stalls until the product lands.
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    checkOutput("mult accept", 32'(mdu_recv), 32'd1);
    applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("mflo stall", 32'(mdu_recv), 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (mdu_recv) break;
      applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    checkOutput("mflo served", 32'(mdu_recv), 32'd1);
    checkOutput("mflo after mult", mdu_result, 32'hFFFF_FFFE);
    idleCycle();
    checkOutput("mult hi", hi_o, 32'hFFFF_FFFF);

    // MTLO behind an MSUBU waits, then overwrites the freshly written LO.
    applyStimulus(OP_MSUBU, 32'd1, 32'd1, 1'b1, 1'b0);
    checkOutput("msubu accept", 32'(mdu_recv), 32'd1);
    applyStimulus(OP_MTLO, 32'h0000_0077, 32'd0, 1'b1, 1'b0);
    checkOutput("mtlo stall", 32'(mdu_recv), 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (mdu_recv) break;
      applyStimulus(OP_MTLO, 32'h0000_0077, 32'd0, 1'b1, 1'b0);
    end
    checkOutput("mtlo served", 32'(mdu_recv), 32'd1);
    idleCycle();
    checkOutput("msubu hi", hi_o, 32'hFFFF_FFFF);
    checkOutput("mtlo lo",  lo_o, 32'h0000_0077);

    // MUL to GPR with the FU waiting: result hand-off exactly MulCycles after accept.
    applyStimulus(OP_MUL, 32'd6, 32'd7, 1'b1, 1'b0);
    checkOutput("gmul accept", 32'(mdu_recv), 32'd1);
    for (int k = 1; k < MulCycles; k++) begin
      applyStimulus(OP_MUL, 32'd6, 32'd7, 1'b1, 1'b1);
      checkOutput("gmul wait", 32'(mdu_recv), 32'd0);
    end
    applyStimulus(OP_MUL, 32'd6, 32'd7, 1'b1, 1'b1);
    checkOutput("gmul recv",   32'(mdu_recv), 32'd1);
    checkOutput("gmul result", mdu_result,    32'd42);
    idleCycle();
    checkOutput("gmul idle",  32'(mdu_busy), 32'd0);
    checkOutput("gmul hi",    hi_o,          32'hFFFF_FFFF);
    checkOutput("gmul lo",    lo_o,          32'h0000_0077);

    // Product is held while the FU presents something else, then handed off.
    applyStimulus(OP_MUL, 32'd5, 32'd9, 1'b1, 1'b0);
    checkOutput("gmul2 accept", 32'(mdu_recv), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b1);
      checkOutput($sformatf("gmul2 hold %0d", k), 32'(mdu_recv), 32'd0);
    end
    checkOutput("gmul2 busy", 32'(mdu_busy), 32'd1);
    applyStimulus(OP_MUL, 32'd0, 32'd0, 1'b1, 1'b1);
    checkOutput("gmul2 recv",   32'(mdu_recv), 32'd1);
    checkOutput("gmul2 result", mdu_result,    32'd45);
    idleCycle();
    checkOutput("gmul2 idle", 32'(mdu_busy), 32'd0);

    // FU flush right after a MUL accept drops the result.
    applyStimulus(OP_MUL, 32'd3, 32'd3, 1'b1, 1'b0);
    checkOutput("flush accept", 32'(mdu_recv), 32'd1);
    idleCycle();
    checkOutput("flush recv", 32'(mdu_recv), 32'd0);
    applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("flush mflo recv",   32'(mdu_recv), 32'd1);
    checkOutput("flush mflo result", mdu_result,    32'h0000_0077);

    // A MUL already marked started never restarts from IDLE.
    applyStimulus(OP_MUL, 32'd2, 32'd2, 1'b1, 1'b1);
    checkOutput("started no restart", 32'(mdu_recv), 32'd0);
    idleCycle();
    checkOutput("started stays idle", 32'(mdu_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
